// File: rtl/gpif_write_arbiter_if.sv
// Bundle of the two source handshakes and the FX3 slave-FIFO write pins
// shared by gpif_write_arbiter and whatever drives or observes it.
interface gpif_write_arbiter_if;
    logic [31:0] s0_data;
    logic        s0_valid;
    logic        s0_last;
    logic        s0_ready;
    logic [31:0] s1_data;
    logic        s1_valid;
    logic        s1_last;
    logic        s1_ready;
    logic        DMA0_Ready;
    logic        DMA1_Ready;
    logic [31:0] DQ;
    logic        WR_n;
    logic        SelectDMA;
    logic        PKTEND_n;
    logic        busy;

    // Arbiter side: consumes source words and flags, drives the FX3 pins.
    modport slave (
        input  s0_data, s0_valid, s0_last,
        input  s1_data, s1_valid, s1_last,
        input  DMA0_Ready, DMA1_Ready,
        output s0_ready, s1_ready,
        output DQ, WR_n, SelectDMA, PKTEND_n, busy
    );

    // Source / environment side.
    modport master (
        output s0_data, s0_valid, s0_last,
        output s1_data, s1_valid, s1_last,
        output DMA0_Ready, DMA1_Ready,
        input  s0_ready, s1_ready,
        input  DQ, WR_n, SelectDMA, PKTEND_n, busy
    );
endinterface

// File: rtl/gpif_write_arbiter.sv
// Round-robin arbiter sharing the FX3 GPIF II slave-FIFO write port between
// two sources. Source 0 always writes DMA socket 0, source 1 socket 1.
// Bursts are bounded by BURST_LEN; a socket change inserts ADDR_SETUP
// address cycles before the first write strobe.
// Optional macro GPIF_WRITE_ARBITER_PKTEND_EN: a word flagged sX_last is
// written together with a one-cycle PKTEND_n pulse and ends the burst.
module gpif_write_arbiter #(
    parameter int BURST_LEN  = 16,
    parameter int ADDR_SETUP = 2
) (
    input  logic          PCLK,
    input  logic          RESET_n,
    gpif_write_arbiter_if.slave bus
);
    localparam int              CNT_W     = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST_LEN);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ADDR  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_TURN  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] beat_q, beat_d;
    logic [2:0]       setup_q, setup_d;
    logic             last_grant_q, last_grant_d;
    logic             sel_q, sel_d;
    logic [31:0]      dq_q, dq_d;
    logic             wr_n_q, wr_n_d;
    logic             pktend_n_q, pktend_n_d;

    logic             elig0_s, elig1_s, pick_s;
    logic             g_valid_s, g_dma_s, g_last_s, g_ready_s, xfer_s;
    logic [31:0]      g_data_s;
    logic [CNT_W-1:0] beat_inc_s;
    logic             pkt_end_s;

    assign elig0_s    = bus.s0_valid & bus.DMA0_Ready;
    assign elig1_s    = bus.s1_valid & bus.DMA1_Ready;

    // SelectDMA doubles as the current grant: it is loaded with every grant.
    assign g_valid_s  = sel_q ? bus.s1_valid   : bus.s0_valid;
    assign g_dma_s    = sel_q ? bus.DMA1_Ready : bus.DMA0_Ready;
    assign g_last_s   = sel_q ? bus.s1_last    : bus.s0_last;
    assign g_data_s   = sel_q ? bus.s1_data    : bus.s0_data;

    // Ready deliberately ignores valid so sources never see a loop.
    assign g_ready_s  = (state_q == ST_WRITE) & g_dma_s & (beat_q < BURST_MAX);
    assign xfer_s     = g_ready_s & g_valid_s;
    assign beat_inc_s = beat_q + CNT_W'(1);

`ifdef GPIF_WRITE_ARBITER_PKTEND_EN
    assign pkt_end_s  = xfer_s & g_last_s;
`else
    logic last_unused_s;
    assign last_unused_s = g_last_s;
    assign pkt_end_s  = 1'b0;
`endif

    assign bus.s0_ready  = g_ready_s & ~sel_q;
    assign bus.s1_ready  = g_ready_s &  sel_q;
    assign bus.DQ        = dq_q;
    assign bus.WR_n      = wr_n_q;
    assign bus.SelectDMA = sel_q;
    assign bus.PKTEND_n  = pktend_n_q;
    assign bus.busy      = (state_q != ST_IDLE);

    // Next-state logic for the arbitration FSM and the registered pins.
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        setup_d      = setup_q;
        last_grant_d = last_grant_q;
        sel_d        = sel_q;
        dq_d         = dq_q;
        wr_n_d       = 1'b1;
        pktend_n_d   = 1'b1;
        pick_s       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (elig0_s | elig1_s) begin
                    pick_s       = (elig0_s & elig1_s) ? ~last_grant_q : elig1_s;
                    last_grant_d = pick_s;
                    sel_d        = pick_s;
                    if ((pick_s != sel_q) && (ADDR_SETUP != 0)) begin
                        setup_d = 3'(ADDR_SETUP);
                        state_d = ST_ADDR;
                    end else begin
                        state_d = ST_WRITE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (setup_q <= 3'd1) begin
                    setup_d = 3'd0;
                    state_d = ST_WRITE;
                end else begin
                    setup_d = setup_q - 3'd1;
                end
            end
            ST_WRITE: begin
                if (xfer_s) begin
                    dq_d       = g_data_s;
                    wr_n_d     = 1'b0;
                    pktend_n_d = ~pkt_end_s;
                    beat_d     = beat_inc_s;
                end else begin
                    wr_n_d     = 1'b1;
                end
                if ((xfer_s && (beat_inc_s == BURST_MAX)) ||
                    (!g_valid_s && g_ready_s) || !g_dma_s || pkt_end_s) begin
                    state_d = ST_TURN;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_TURN: begin
                beat_d  = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge PCLK) begin
        if (!RESET_n) begin
            state_q      <= ST_IDLE;
            beat_q       <= '0;
            setup_q      <= 3'd0;
            last_grant_q <= 1'b1;
            sel_q        <= 1'b0;
            dq_q         <= 32'd0;
            wr_n_q       <= 1'b1;
            pktend_n_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            setup_q      <= setup_d;
            last_grant_q <= last_grant_d;
            sel_q        <= sel_d;
            dq_q         <= dq_d;
            wr_n_q       <= wr_n_d;
            pktend_n_q   <= pktend_n_d;
        end
    end
endmodule

// File: tb/tb_gpif_write_arbiter.sv
// Scoreboard bench for gpif_write_arbiter (BURST_LEN=16, ADDR_SETUP=2).
// Source models hold word queues; each word loaded is also pushed onto the
// expected queue of its socket, and a negedge monitor pops and compares on
// every WR_n low. Scenario code checks burst shapes from the write log.
module tb_gpif_write_arbiter;
    localparam int BL = 16;
    localparam int AS = 2;

    typedef struct { logic [31:0] d; logic l; } word_t;
    typedef struct { logic sel; int cyc; } wr_t;

    logic PCLK = 1'b0;
    logic RESET_n = 1'b0;
    gpif_write_arbiter_if ifc();

    gpif_write_arbiter #(.BURST_LEN(BL), .ADDR_SETUP(AS)) dut (
        .PCLK(PCLK), .RESET_n(RESET_n), .bus(ifc.slave)
    );

    always #5 PCLK = ~PCLK;

    word_t q0[$], q1[$], exp0[$], exp1[$];
    wr_t   wlog[$];
    int    gapq[$];
    bit    en0 = 1'b0, en1 = 1'b0;
    int    acc0 = 0, acc1 = 0;
    int    tests = 0, fails = 0;
    int    cyc = 0, chg_cyc = 0;
    bit    mon_en = 1'b0, gap_pend = 1'b0;
    logic  prev_sel = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive();
        ifc.s0_valid = en0 && (q0.size() > 0);
        ifc.s0_data  = (q0.size() > 0) ? q0[0].d : 32'd0;
        ifc.s0_last  = (q0.size() > 0) ? q0[0].l : 1'b0;
        ifc.s1_valid = en1 && (q1.size() > 0);
        ifc.s1_data  = (q1.size() > 0) ? q1[0].d : 32'd0;
        ifc.s1_last  = (q1.size() > 0) ? q1[0].l : 1'b0;
    endtask

    task automatic load(input bit src, input logic [31:0] d, input bit l);
        word_t w, e;
        w.d = d; w.l = l;
        e.d = d;
`ifdef GPIF_WRITE_ARBITER_PKTEND_EN
        e.l = l;
`else
        e.l = 1'b0;
`endif
        if (src) begin q1.push_back(w); exp1.push_back(e); end
        else     begin q0.push_back(w); exp0.push_back(e); end
        drive();
    endtask

    // One PCLK: note handshakes seen at the edge, then advance the sources.
    task automatic tick();
        bit a0, a1;
        @(posedge PCLK);
        a0 = ifc.s0_valid && ifc.s0_ready;
        a1 = ifc.s1_valid && ifc.s1_ready;
        #1;
        if (a0 && q0.size() > 0) begin void'(q0.pop_front()); acc0++; end
        if (a1 && q1.size() > 0) begin void'(q1.pop_front()); acc1++; end
        drive();
    endtask

    task automatic drain(input string nm, input int budget);
        int n = 0;
        while ((q0.size() + q1.size() + exp0.size() + exp1.size() > 0) && n < budget) begin
            tick();
            n++;
        end
        check({nm, "_timeout"}, {31'd0, n < budget}, 32'd1);
        repeat (4) tick();
    endtask

    task automatic check_runs(input string nm, input int start, input int n,
                              input int es[4], input int el[4]);
        int rs[$], rl[$];
        for (int i = start; i < wlog.size(); i++) begin
            if (rs.size() > 0 && rs[rs.size()-1] == int'(wlog[i].sel))
                rl[rl.size()-1] = rl[rl.size()-1] + 1;
            else begin
                rs.push_back(int'(wlog[i].sel));
                rl.push_back(1);
            end
        end
        check({nm, "_run_count"}, rs.size(), n);
        for (int i = 0; i < n && i < rs.size(); i++) begin
            check($sformatf("%s_run%0d_sock", nm, i), rs[i], es[i]);
            check($sformatf("%s_run%0d_len", nm, i), rl[i], el[i]);
        end
    endtask

    // Monitor: scoreboard pop on every write strobe, idle PKTEND_n check.
    always @(negedge PCLK) begin
        word_t e;
        cyc = cyc + 1;
        if (mon_en) begin
            if (ifc.SelectDMA !== prev_sel) begin
                gap_pend = 1'b1;
                chg_cyc  = cyc;
                prev_sel = ifc.SelectDMA;
            end
            if (ifc.WR_n === 1'b0) begin
                wlog.push_back('{sel: ifc.SelectDMA, cyc: cyc});
                if (gap_pend) begin gapq.push_back(cyc - chg_cyc); gap_pend = 1'b0; end
                if (ifc.SelectDMA === 1'b0) begin
                    check("s0_write_expected", {31'd0, exp0.size() != 0}, 32'd1);
                    if (exp0.size() != 0) begin
                        e = exp0.pop_front();
                        check("s0_dq", ifc.DQ, e.d);
                        check("s0_pktend", {31'd0, ~ifc.PKTEND_n}, {31'd0, e.l});
                    end
                end else begin
                    check("s1_write_expected", {31'd0, exp1.size() != 0}, 32'd1);
                    if (exp1.size() != 0) begin
                        e = exp1.pop_front();
                        check("s1_dq", ifc.DQ, e.d);
                        check("s1_pktend", {31'd0, ~ifc.PKTEND_n}, {31'd0, e.l});
                    end
                end
            end else begin
                check("pktend_idle", {31'd0, ifc.PKTEND_n}, 32'd1);
            end
        end
    end

    initial begin
        int start, n;
        ifc.DMA0_Ready = 1'b1;
        ifc.DMA1_Ready = 1'b1;
        drive();

        // Reset with both sources valid, then alternating bursts.
        for (int i = 0; i < 20; i++) load(1'b0, 32'h0A00_0000 + i, 1'b0);
        for (int i = 0; i < 20; i++) load(1'b1, 32'h0B00_0000 + i, 1'b0);
        en0 = 1'b1; en1 = 1'b1; drive();
        repeat (3) tick();
        check("rst_wr_n", {31'd0, ifc.WR_n}, 32'd1);
        check("rst_sel", {31'd0, ifc.SelectDMA}, 32'd0);
        check("rst_dq", ifc.DQ, 32'd0);
        check("rst_busy", {31'd0, ifc.busy}, 32'd0);
        check("rst_pktend", {31'd0, ifc.PKTEND_n}, 32'd1);
        check("rst_s0_ready", {31'd0, ifc.s0_ready}, 32'd0);
        prev_sel = ifc.SelectDMA;
        gap_pend = 1'b0;
        mon_en   = 1'b1;
        start    = wlog.size();
        RESET_n  = 1'b1;
        drain("alt", 400);
        check("alt_first_sel", {31'd0, wlog[start].sel}, 32'd0);
        check_runs("alt", start, 4, '{0, 1, 0, 1}, '{16, 16, 4, 4});
        check("alt_gap_count", gapq.size(), 3);
        // New socket visible for AS address cycles plus the accept cycle.
        foreach (gapq[i]) check($sformatf("alt_gap%0d", i), gapq[i], AS + 1);

        // Single source, 20 words: full burst, TURN, IDLE, short burst.
        en1 = 1'b0;
        start = wlog.size();
        for (int i = 0; i < 20; i++) load(1'b0, 32'h0C00_0000 + i, 1'b0);
        drain("solo", 200);
        check_runs("solo", start, 1, '{0, 0, 0, 0}, '{20, 0, 0, 0});
        if (wlog.size() >= start + 20) begin
            check("solo_burst_span", wlog[start+15].cyc - wlog[start].cyc, 15);
            check("solo_regrant_gap", wlog[start+16].cyc - wlog[start+15].cyc, 3);
            check("solo_tail_span", wlog[start+19].cyc - wlog[start+16].cyc, 3);
        end

        // DMA1_Ready drops after 5 words of s1; grant moves to s0.
        en0 = 1'b0; en1 = 1'b1;
        start = wlog.size();
        for (int i = 0; i < 10; i++) load(1'b1, 32'h0D00_0000 + i, 1'b0);
        for (int i = 0; i < 6; i++)  load(1'b0, 32'h0E00_0000 + i, 1'b0);
        acc1 = 0; n = 0;
        while (acc1 < 5 && n < 100) begin tick(); n++; end
        check("drop_wait_timeout", {31'd0, n < 100}, 32'd1);
        ifc.DMA1_Ready = 1'b0;
        en0 = 1'b1; drive();
        #1;
        check("drop_s1_ready", {31'd0, ifc.s1_ready}, 32'd0);
        n = 0;
        while ((q0.size() + exp0.size() > 0) && n < 100) begin tick(); n++; end
        check("drop_s0_timeout", {31'd0, n < 100}, 32'd1);
        n = 0;
        for (int i = start; i < wlog.size(); i++) if (wlog[i].sel) n++;
        check("drop_s1_writes", n, 5);
        ifc.DMA1_Ready = 1'b1; drive();
        drain("drop", 200);
        check_runs("drop", start, 3, '{1, 0, 1, 0}, '{5, 6, 5, 0});

        // Reset at word 7 of an s1 burst.
        en0 = 1'b0; en1 = 1'b1;
        for (int i = 0; i < 20; i++) load(1'b1, 32'h0F00_0000 + i, 1'b0);
        acc1 = 0; n = 0;
        while (acc1 < 7 && n < 100) begin tick(); n++; end
        check("mid_wait_timeout", {31'd0, n < 100}, 32'd1);
        check("mid_busy_before", {31'd0, ifc.busy}, 32'd1);
        RESET_n = 1'b0;
        tick();
        check("mid_rst_wr_n", {31'd0, ifc.WR_n}, 32'd1);
        check("mid_rst_busy", {31'd0, ifc.busy}, 32'd0);
        check("mid_rst_sel", {31'd0, ifc.SelectDMA}, 32'd0);
        check("mid_rst_dq", ifc.DQ, 32'd0);
        q0.delete(); q1.delete(); exp0.delete(); exp1.delete();
        drive();
        tick();
        RESET_n = 1'b1;
        start = wlog.size();
        for (int i = 0; i < 3; i++) load(1'b0, 32'h1100_0000 + i, 1'b0);
        for (int i = 0; i < 3; i++) load(1'b1, 32'h1200_0000 + i, 1'b0);
        en0 = 1'b1; drive();
        drain("post", 200);
        check_runs("post", start, 2, '{0, 1, 0, 0}, '{3, 3, 0, 0});

        // s0_last on word 3.
        en1 = 1'b0;
        start = wlog.size();
        for (int i = 0; i < 6; i++) load(1'b0, 32'h1000_0000 + i, (i == 3));
        drain("pkt", 200);
        check_runs("pkt", start, 1, '{0, 0, 0, 0}, '{6, 0, 0, 0});
        if (wlog.size() >= start + 6) begin
            check("pkt_pre_span", wlog[start+3].cyc - wlog[start].cyc, 3);
`ifdef GPIF_WRITE_ARBITER_PKTEND_EN
            check("pkt_end_gap", wlog[start+4].cyc - wlog[start+3].cyc, 3);
`else
            check("pkt_end_gap", wlog[start+4].cyc - wlog[start+3].cyc, 1);
`endif
        end

        check("exp0_empty", exp0.size(), 0);
        check("exp1_empty", exp1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
